// File: rtl/jt12_wrq_pkg.sv
// Shared types and constants for the jt12 register-write queue.
package jt12_wrq_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAPW, BUSYW} state_t;

  localparam int   ENTRY_W   = 10;
  localparam int   BUSY_BIT  = 7;
  localparam logic PORT_ADDR = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef struct packed {
    logic [1:0] addr;
    logic [7:0] din;
  } entry_t;
endpackage

// File: rtl/jt12_wrq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushes while full and pops while empty are ignored.
module jt12_wrq_fifo
  import jt12_wrq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);
  entry_t      mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign level   = wptr - rptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/jt12_wrq.sv
// CPU-side write queue for jt12: buffers writes and replays them as cs_n/wr_n strobes,
// waiting out the busy flag after data writes. Optional busy timeout: JT12_WRQ_TIMEOUT_EN.
module jt12_wrq
  import jt12_wrq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AW        = 4,
  parameter int WR_CYCLES = 2,
  parameter int GAP       = 2,
  parameter int BUSY_MIN  = 4,
  parameter int TIMEOUT   = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_we,
  input  logic [1:0]    cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic          cpu_full,
  output logic          cpu_empty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          opn_cs_n,
  output logic          opn_wr_n,
  output logic [1:0]    opn_addr,
  output logic [7:0]    opn_din,
  input  logic [7:0]    opn_dout,
  output logic          timeout_flag,
  input  logic          timeout_clr
);
  // One counter serves strobe width, gap, busy settle and (optionally) the timeout.
  localparam int CW = $clog2(WR_CYCLES + GAP + BUSY_MIN + TIMEOUT + 2);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  entry_t          head;
  logic            pop, fifo_empty, tmo_set;

  jt12_wrq_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cpu_we),
    .pop   (pop),
    .wdata ({cpu_addr, cpu_din}),
    .rdata (head),
    .full  (cpu_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign cpu_empty = fifo_empty && (state == IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pop      = 1'b0;
    tmo_set  = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) begin
        pop      = 1'b1;
        state_nx = SETUP;
      end
      SETUP: begin
        state_nx = STROBE;
        cnt_nx   = '0;
      end
      STROBE: if (cnt == CW'(WR_CYCLES - 1)) state_nx = HOLD;
              else cnt_nx = cnt + 1'b1;
      HOLD: begin
        cnt_nx = '0;
        if (opn_addr[0] == PORT_DATA) state_nx = BUSYW;
        else if (GAP == 0)            state_nx = IDLE;
        else                          state_nx = GAPW;
      end
      GAPW: if (cnt == CW'(GAP - 1)) state_nx = IDLE;
            else cnt_nx = cnt + 1'b1;
      BUSYW: begin
        // busy is ignored until it has had time to propagate through jt12
        if (cnt < CW'(BUSY_MIN)) cnt_nx = cnt + 1'b1;
        else if (!opn_dout[BUSY_BIT]) state_nx = IDLE;
`ifdef JT12_WRQ_TIMEOUT_EN
        else if (cnt == CW'(BUSY_MIN + TIMEOUT - 1)) begin
          state_nx = IDLE;
          tmo_set  = 1'b1;
        end else cnt_nx = cnt + 1'b1;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      opn_cs_n <= 1'b1;
      opn_wr_n <= 1'b1;
      opn_addr <= '0;
      opn_din  <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      opn_cs_n <= !(state_nx inside {SETUP, STROBE, HOLD});
      opn_wr_n <= (state_nx != STROBE);
      if (pop) {opn_addr, opn_din} <= head;
      if (cpu_we && cpu_full) ovf <= 1'b1;
    end
  end

`ifdef JT12_WRQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           timeout_flag <= 1'b0;
    else if (tmo_set)     timeout_flag <= 1'b1;
    else if (timeout_clr) timeout_flag <= 1'b0;
  end
  logic unused_bits;
  assign unused_bits = ^opn_dout[6:0];
`else
  assign timeout_flag = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{opn_dout[6:0], timeout_clr, tmo_set};
`endif
endmodule

// File: tb/tb_jt12_wrq.sv
// Bench for jt12_wrq: transaction-level timeline model plus directed and random stimulus.
module tb_jt12_wrq;
  localparam int DEPTH = 16, AW = 4, WR = 2, GAP = 2, BMIN = 4, TMO = 1023;

  logic clk = 1'b0, rst_n = 1'b0, cpu_we = 1'b0, timeout_clr = 1'b0;
  logic [1:0]  cpu_addr = '0;
  logic [7:0]  cpu_din = '0, opn_dout = '0;
  logic        cpu_full, cpu_empty, ovf, opn_cs_n, opn_wr_n, timeout_flag;
  logic [AW:0] level;
  logic [1:0]  opn_addr;
  logic [7:0]  opn_din;

  jt12_wrq #(.DEPTH(DEPTH), .AW(AW), .WR_CYCLES(WR), .GAP(GAP), .BUSY_MIN(BMIN), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_full(cpu_full), .cpu_empty(cpu_empty), .level(level), .ovf(ovf),
    .opn_cs_n(opn_cs_n), .opn_wr_n(opn_wr_n), .opn_addr(opn_addr), .opn_din(opn_din),
    .opn_dout(opn_dout), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Model: queue of pending writes plus the start cycle of the write on the bus.
  logic [9:0] q[$];
  bit         m_act, m_ovf, m_tf;
  longint     n, m_s;
  logic [9:0] cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_act = 0; m_ovf = 0; m_tf = 0; n = 0; m_s = 0; cur = '0;
  endtask

  // Advance the model across one clock edge using the inputs of cycle n.
  task automatic model_edge();
    bit pop, push, drop, tset;
    longint b;
    pop  = !m_act && q.size() > 0;
    push = cpu_we && q.size() < DEPTH;
    drop = cpu_we && q.size() == DEPTH;
    tset = 0;
    if (m_act) begin
      b = m_s + WR + 2;
      if (!cur[8]) begin
        if (n == m_s + WR + 1 + GAP) m_act = 0;
      end else if (n >= b + BMIN) begin
        if (!opn_dout[7]) m_act = 0;
`ifdef JT12_WRQ_TIMEOUT_EN
        else if (n == b + BMIN + TMO - 1) begin m_act = 0; tset = 1; end
`endif
      end
    end
`ifdef JT12_WRQ_TIMEOUT_EN
    if (tset) m_tf = 1;
    else if (timeout_clr) m_tf = 0;
`endif
    if (pop) begin cur = q.pop_front(); m_act = 1; m_s = n + 1; end
    if (push) q.push_back({cpu_addr, cpu_din});
    if (drop) m_ovf = 1;
    n++;
  endtask

  task automatic compare();
    logic exp_cs, exp_wr;
    exp_cs = !(m_act && n >= m_s && n <= m_s + WR + 1);
    exp_wr = !(m_act && n >= m_s + 1 && n <= m_s + WR);
    chk("cs_n", opn_cs_n, exp_cs);
    chk("wr_n", opn_wr_n, exp_wr);
    chk("opn_addr", opn_addr, cur[9:8]);
    chk("opn_din", opn_din, cur[7:0]);
    chk("level", level, q.size());
    chk("cpu_full", cpu_full, q.size() == DEPTH);
    chk("cpu_empty", cpu_empty, !m_act && q.size() == 0);
    chk("ovf", ovf, m_ovf);
    chk("timeout_flag", timeout_flag, m_tf);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    compare();
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    step();
    cpu_we = 1'b0;
  endtask

  initial begin
    logic cs_h[16], wr_h[16], em_h[16];
    int first_low, cs_cnt, wr_cnt, start3, cnt;
    bit got, prev_cs, seen_low;
    logic [7:0] seq[$];

    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    compare();
    chk("rst_cs_n", opn_cs_n, 1);
    chk("rst_level", level, 0);

    // single address write
    wr(2'd0, 8'h28);
    for (int k = 1; k <= 12; k++) begin
      cs_h[k] = opn_cs_n; wr_h[k] = opn_wr_n; em_h[k] = cpu_empty;
      step();
    end
    first_low = -1; cs_cnt = 0; wr_cnt = 0;
    for (int k = 12; k >= 1; k--) if (!cs_h[k]) first_low = k;
    for (int k = 1; k <= 12; k++) begin
      if (!cs_h[k]) cs_cnt++;
      if (!wr_h[k]) wr_cnt++;
    end
    chk("t1_cs_latency", first_low, 2);
    chk("t1_cs_len", cs_cnt, 4);
    chk("t1_wr_len", wr_cnt, 2);
    chk("t1_empty_in_gap", em_h[7], 0);
    chk("t1_empty_after_gap", em_h[8], 1);

    // address, data, then a third write held back by busy
    opn_dout = 8'h80;
    wr(2'd0, 8'h28); wr(2'd1, 8'hF0); wr(2'd0, 8'h55);
    start3 = -1;
    for (int k = 3; k <= 34; k++) begin
      if (k >= 20) opn_dout = 8'h00;
      if (!opn_cs_n && opn_din == 8'h55 && start3 < 0) start3 = k;
      step();
    end
    chk("t2_third_start", start3, 22);

    // burst of 17 writes while the engine is parked in the busy wait
    opn_dout = 8'h80;
    wr(2'd1, 8'h11);
    repeat (10) step();
    for (int i = 0; i < 17; i++) begin
      if (i == 16) chk("t3_ovf_before", ovf, 0);
      cpu_we = 1'b1; cpu_addr = 2'($urandom); cpu_din = 8'(i);
      step();
    end
    cpu_we = 1'b0;
    chk("t3_level", level, 16);
    chk("t3_full", cpu_full, 1);
    chk("t3_ovf", ovf, 1);
    opn_dout = 8'h00;
    repeat (260) step();
    chk("t3_drained", cpu_empty, 1);

    // push coinciding with pop at level 3, order preserved
    opn_dout = 8'h80;
    wr(2'd1, 8'h00);
    repeat (10) step();
    wr(2'd0, 8'h01); wr(2'd0, 8'h02); wr(2'd0, 8'h03);
    chk("t4_level3", level, 3);
    opn_dout = 8'h00;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (!m_act && q.size() > 0) begin
        cpu_we = 1'b1; cpu_addr = 2'd0; cpu_din = 8'h04;
        got = 1;
      end
      step();
      cpu_we = 1'b0;
    end
    chk("t4_pushpop_seen", got, 1);
    chk("t4_level_kept", level, 3);
    prev_cs = 1;
    for (int k = 0; k < 40; k++) begin
      if (prev_cs && !opn_cs_n) seq.push_back(opn_din);
      prev_cs = opn_cs_n;
      step();
    end
    chk("t4_seq_len", seq.size(), 4);
    for (int i = 0; i < 4 && i < seq.size(); i++) chk("t4_seq", seq[i], i + 1);

    // asynchronous reset during the write strobe
    wr(2'd0, 8'h33); wr(2'd0, 8'h44);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (!opn_wr_n) got = 1; else step();
    end
    chk("t5_in_strobe", got, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_cs_n", opn_cs_n, 1);
    chk("t5_async_wr_n", opn_wr_n, 1);
    chk("t5_async_level", level, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    compare();
    cs_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (!opn_cs_n) cs_cnt++;
      step();
    end
    chk("t5_no_strobe", cs_cnt, 0);

    // randomized traffic with a wandering busy flag
    for (int k = 0; k < 3000; k++) begin
      cpu_we = ($urandom_range(99) < 35);
      cpu_addr = 2'($urandom);
      cpu_din = 8'($urandom);
      if ($urandom_range(99) < 20) opn_dout[7] = ~opn_dout[7];
      opn_dout[6:0] = 7'($urandom);
      timeout_clr = ($urandom_range(99) < 3);
      step();
    end
    cpu_we = 1'b0; timeout_clr = 1'b0; opn_dout = 8'h00;
    repeat (300) step();
    chk("t6_drained", cpu_empty, 1);

    // busy stuck high
    opn_dout = 8'h80;
    wr(2'd1, 8'h99);
    got = 0; seen_low = 0; prev_cs = opn_cs_n;
    for (int k = 0; k < 15 && !got; k++) begin
      step();
      if (!opn_cs_n) seen_low = 1;
      if (seen_low && !prev_cs && opn_cs_n) got = 1;
      prev_cs = opn_cs_n;
    end
    chk("t7_strobe_done", got, 1);
    cnt = 0;
`ifdef JT12_WRQ_TIMEOUT_EN
    while (!cpu_empty && cnt < 1100) begin step(); cnt++; end
    chk("t7_busyw_len", cnt, BMIN + TMO);
    chk("t7_tflag_set", timeout_flag, 1);
    timeout_clr = 1'b1; step(); timeout_clr = 1'b0;
    chk("t7_tflag_clr", timeout_flag, 0);
`else
    while (cnt < 1100) begin step(); cnt++; end
    chk("t7_still_waiting", cpu_empty, 0);
    chk("t7_tflag_zero", timeout_flag, 0);
`endif
    opn_dout = 8'h00;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/jt12_wrq.md
Name: jt12_wrq

Overview:
- Register-write queue that sits directly upstream of the jt12 core, on its CPU bus port.
- Accepts back-to-back CPU writes (address/data pairs on the 2-bit YM2612 address space) into a FIFO.
- Replays them to jt12 as properly timed cs_n/wr_n strobes.
- After each data write, waits for the jt12 busy flag (dout[7]) to clear before issuing the next write, so the CPU never stalls on the chip.

Parameters:
- DEPTH, 16, FIFO entries (power of 2, ≥2); each entry is {addr[1:0], din[7:0]}.
- AW, 4, log2(DEPTH).
- WR_CYCLES, 2, cycles wr_n is held low per strobe (≥1).
- GAP, 2, idle cycles after an address-port write before the next strobe (≥0).
- BUSY_MIN, 4, cycles to wait after a data-port write before busy is sampled (≥1; covers busy latency through jt12 clock sync).
- TIMEOUT, 1023, max busy-wait cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, same clock as jt12 clk.
- rst_n  in  1  asynchronous active-low reset.
- cpu_we  in  1  single-cycle write request.
- cpu_addr  in  2  YM2612 port (0/2 = address, 1/3 = data).
- cpu_din  in  8  write data.
- cpu_full  out  1  FIFO full; a write in this cycle is dropped.
- cpu_empty  out  1  FIFO empty and FSM in IDLE (all writes delivered).
- level  out  AW+1  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky: a write was dropped while full; cleared only by reset.
- opn_cs_n  out  1  to jt12 cs_n.
- opn_wr_n  out  1  to jt12 wr_n.
- opn_addr  out  2  to jt12 addr.
- opn_din  out  8  to jt12 din.
- opn_dout  in  8  from jt12 dout; bit 7 = busy.
- timeout_flag  out  1  sticky busy timeout (see Optional Feature).
- timeout_clr  in  1  clears timeout_flag.

Behaviour:
- One clock. Reset is asynchronous, active-low.
- Reset values: opn_cs_n=1, opn_wr_n=1, opn_addr=0, opn_din=0, cpu_full=0, cpu_empty=1, level=0, ovf=0, timeout_flag=0. FIFO pointers are cleared and the FSM enters IDLE.
- Reset asserted mid-strobe deasserts cs_n/wr_n immediately (asynchronous) and discards all queued entries.
- Push: when cpu_we=1 and not full, the entry is written at the rising edge.
  - Fullness is evaluated before any same-cycle pop; a write while full is dropped and sets ovf.
  - Push and pop in the same cycle leave level unchanged.
- Pointers are AW+1 bits and wrap modulo 2·DEPTH. full = MSBs differ with equal low bits; empty = pointers equal.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAPW, BUSYW.
  - IDLE: if FIFO not empty, pop the head into the opn_addr/opn_din registers; go to SETUP. Latency from push into an empty, idle queue to cs_n low is 2 cycles.
  - SETUP (1 cycle): cs_n=0, wr_n=1, addr/din stable.
  - STROBE (WR_CYCLES cycles): cs_n=0, wr_n=0.
  - HOLD (1 cycle): cs_n=0, wr_n=1, addr/din still stable.
  - After HOLD: if addr[0]=0, go to GAPW (GAP cycles, cs_n=1; skipped if GAP=0, straight to IDLE). If addr[0]=1, go to BUSYW.
  - BUSYW: cs_n=1. A counter runs BUSY_MIN cycles; thereafter, return to IDLE on the first cycle with opn_dout[7]=0.
- opn_addr/opn_din change only on the IDLE→SETUP transition.
- cpu_empty = FIFO empty AND state==IDLE.

Optional Feature:
- Macro: JT12_WRQ_TIMEOUT_EN.
- Enabled: BUSYW also counts cycles spent past BUSY_MIN. On reaching TIMEOUT with busy still 1, the FSM proceeds to IDLE and sets timeout_flag (sticky; cleared by timeout_clr; set has priority on the same cycle).
- Disabled: BUSYW waits indefinitely, no timeout counter is built, timeout_flag is tied to 0, and timeout_clr is ignored.

Decomposition:
- Package jt12_wrq_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, HOLD, GAPW, BUSYW);
  - the entry width constant (10);
  - the index of the busy bit (7);
  - the address-port LSB meaning (0 = address, 1 = data).
- One sub-module, jt12_wrq_fifo: synchronous FIFO with push/pop/full/empty/level, parameterised by DEPTH and AW.
- The FSM and strobe counters stay in the top.

Test Plan:
- Reset then single write (addr=0, din=0x28): cs_n low 2 cycles after push for 1+WR_CYCLES+1=4 cycles, wr_n low exactly 2 cycles, then GAP=2 idle cycles and cpu_empty=1.
- Pair addr=0/0x28 then addr=1/0xF0 with opn_dout[7] forced 1 for 20 cycles: the next queued write starts only after busy drops and no earlier than BUSY_MIN=4 cycles after HOLD.
- Burst of 17 writes in 17 consecutive cycles with busy held 1: level reaches 16, cpu_full=1, and ovf=1 on the 17th write.
- Reset pulse during STROBE: opn_cs_n and opn_wr_n go to 1 asynchronously (before the next clock edge), level=0, and no strobe after release.
- Push while a pop occurs at level=3: level stays 3 and order is preserved (opn_din sequence matches push order 0x01, 0x02, 0x03, ...).
- With JT12_WRQ_TIMEOUT_EN and TIMEOUT=1023, busy stuck at 1: the FSM leaves BUSYW after BUSY_MIN+1023 cycles, timeout_flag=1, and timeout_clr returns it to 0. Without the macro, the FSM remains in BUSYW.
